// File: rtl/iir_inverse_decoder.sv
// iir_inverse_decoder
// Recovers the 8-bit sample stream x[n] from the 13-bit output of the
// third-order IIR encoder
//   y = x_ext - x[n-1] + x[n-2] + x[n-3] + (y[n-1]>>1) - (y[n-2]>>2)  (mod 2^13)
// by running the inverse recurrence in the same modulo-2^13 arithmetic.
// Recovery is therefore bit-exact.
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   in_valid     : y_in holds a new encoded sample this cycle
//   y_in         : encoded sample y[n] (unsigned, 2 fractional bits)
//   x_out        : recovered sample x[n], registered
//   out_valid    : one-cycle pulse, 1 cycle after each accepted input
//   err          : sticky format-check failure, cleared only by rst
//   locked       : high while in RUN (history fully populated, no errors)
//   sample_cnt   : accepted-sample count, saturating
module iir_inverse_decoder #(
  parameter int NB_input       = 8,
  parameter int NB_o_fullscale = 13,
  parameter int NB_count       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [NB_o_fullscale-1:0] y_in,
  output logic [NB_input-1:0]       x_out,
  output logic                      out_valid,
  output logic                      err,
  output logic                      locked,
  output logic [NB_count-1:0]       sample_cnt
);

  localparam int NB_FRAC = 2;
  localparam int NB_HI   = NB_o_fullscale - NB_input - NB_FRAC;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    ERROR  = 2'd2
  } state_t;

  state_t state;
  logic [1:0] warm_cnt;

  // y history holds raw accepted inputs; xr history holds full-width x_rec
  // so the fractional and guard bits feed back exactly as the encoder saw them.
  logic [NB_o_fullscale-1:0] y1, y2;
  logic [NB_o_fullscale-1:0] xr1, xr2, xr3;
  logic [NB_o_fullscale-1:0] x_rec;
  logic                      fmt_ok;

  // All terms share one width, so the sum wraps mod 2^13 in any order.
  always_comb begin
    x_rec  = y_in - (y1 >> 1) + (y2 >> 2) + xr1 - xr2 - xr3;
    fmt_ok = (x_rec[NB_FRAC-1:0] == '0) &&
             (x_rec[NB_o_fullscale-1:NB_o_fullscale-NB_HI] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y1         <= '0;
      y2         <= '0;
      xr1        <= '0;
      xr2        <= '0;
      xr3        <= '0;
      x_out      <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      locked     <= 1'b0;
      sample_cnt <= '0;
      state      <= WARMUP;
      warm_cnt   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        x_out <= x_rec[NB_input+NB_FRAC-1:NB_FRAC];
        y2    <= y1;
        y1    <= y_in;
        xr3   <= xr2;
        xr2   <= xr1;
        xr1   <= x_rec;
        if (sample_cnt != '1)
          sample_cnt <= sample_cnt + 1'b1;
        if (!fmt_ok)
          err <= 1'b1;

        case (state)
          WARMUP: begin
            if (!fmt_ok) begin
              state  <= ERROR;
              locked <= 1'b0;
            end else if (warm_cnt == 2'd2) begin
              // third clean sample: history now fully populated
              state  <= RUN;
              locked <= 1'b1;
            end else begin
              warm_cnt <= warm_cnt + 1'b1;
            end
          end
          RUN: begin
            if (!fmt_ok) begin
              state  <= ERROR;
              locked <= 1'b0;
            end
          end
          default: begin
            // ERROR is absorbing until rst
            state  <= ERROR;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iir_inverse_decoder.sv
module tb_iir_inverse_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [12:0] y_in;
  logic [7:0]  x_out;
  logic        out_valid;
  logic        err;
  logic        locked;
  logic [15:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  // reference encoder state (x history kept as 13-bit x_ext)
  logic [12:0] ex1, ex2, ex3, ey1, ey2;

  iir_inverse_decoder #(.NB_input(8), .NB_o_fullscale(13), .NB_count(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .y_in(y_in),
    .x_out(x_out), .out_valid(out_valid), .err(err),
    .locked(locked), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock: inputs applied, edge taken, outputs settled 1 time unit later
  task automatic step(input logic r, input logic v, input logic [12:0] y);
    rst = r; in_valid = v; y_in = y;
    @(posedge clk); #1;
  endtask

  task automatic enc_reset();
    ex1 = '0; ex2 = '0; ex3 = '0; ey1 = '0; ey2 = '0;
  endtask

  task automatic enc(input logic [7:0] x, output logic [12:0] y);
    logic [12:0] xe;
    xe = {3'b000, x, 2'b00};
    y  = xe - ex1 + ex2 + ex3 + (ey1 >> 1) - (ey2 >> 2);
    ex3 = ex2; ex2 = ex1; ex1 = xe;
    ey2 = ey1; ey1 = y;
  endtask

  initial begin
    logic [12:0] y;
    logic [7:0]  x, last_x;
    logic        v;
    int          nval;

    rst = 1'b1; in_valid = 1'b0; y_in = '0;
    enc_reset();

    // reset state
    step(1, 0, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_locked", locked, 0);
    chk("rst_cnt", sample_cnt, 0);

    // zero stream: lock after the third sample
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0);
      chk("zero_x_out", x_out, 0);
      chk("zero_out_valid", out_valid, 1);
      chk("zero_locked", locked, (i >= 2) ? 1 : 0);
    end
    step(0, 0, 0);
    chk("zero_stall_valid", out_valid, 0);
    chk("zero_cnt", sample_cnt, 10);
    chk("zero_err", err, 0);

    // impulse: 4 -> x=1, then 8190 -> x_rec = 8190-2+4 = 8192 = 0
    step(1, 0, 0);
    step(0, 1, 13'd4);
    chk("imp_x0", x_out, 1);
    step(0, 1, 13'd8190);
    chk("imp_x1", x_out, 0);
    chk("imp_err", err, 0);
    chk("imp_locked", locked, 0);

    // loopback: 500 back-to-back, then 500 with random stalls
    step(1, 0, 0);
    enc_reset();
    nval = 0; last_x = '0;
    for (int i = 0; i < 1000; i++) begin
      x = (i == 0) ? 8'd0 : (i == 1) ? 8'd255 : (i == 2) ? 8'd255 : 8'($urandom);
      v = (i < 500) ? 1'b1 : ($urandom_range(3) != 0);
      if (i < 3) v = 1'b1;
      if (v) begin
        enc(x, y);
        step(0, 1, y);
        nval++;
        last_x = x;
        chk("lb_x_out", x_out, x);
        chk("lb_out_valid", out_valid, 1);
      end else begin
        step(0, 0, 13'($urandom));
        chk("lb_stall_valid", out_valid, 0);
        chk("lb_stall_hold", x_out, last_x);
      end
    end
    chk("lb_cnt", sample_cnt, nval);
    chk("lb_err", err, 0);
    chk("lb_locked", locked, 1);

    // format failure on first sample, then sticky across good data
    step(1, 0, 0);
    enc_reset();
    step(0, 1, 13'd1);
    chk("bad_x_out", x_out, 0);
    chk("bad_err", err, 1);
    chk("bad_locked", locked, 0);
    for (int i = 0; i < 5; i++) begin
      enc(8'(10 * i + 3), y);
      step(0, 1, y);
      chk("bad_err_sticky", err, 1);
      chk("bad_locked_low", locked, 0);
    end
    step(1, 0, 0);
    enc_reset();
    chk("bad_rst_err", err, 0);
    enc(8'd37, y);
    step(0, 1, y);
    chk("bad_recover_x", x_out, 37);
    chk("bad_recover_err", err, 0);

    // reset wins over a simultaneous valid input
    enc(8'd90, y);
    step(0, 1, y);
    step(1, 1, 13'd123);
    chk("midrst_x_out", x_out, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cnt", sample_cnt, 0);
    chk("midrst_err", err, 0);
    step(0, 1, 13'd20);
    chk("midrst_x5", x_out, 5);
    chk("midrst_cnt1", sample_cnt, 1);
    chk("midrst_locked", locked, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_inverse_decoder.md
Name: iir_inverse_decoder

Overview:
- Recovers the original 8-bit unsigned sample stream x[n] from the 13-bit output y[n] of the team's third-order IIR encoder, which computes y = x_ext - x[n-1] + x[n-2] + x[n-3] + (y[n-1]>>1) - (y[n-2]>>2) mod 2^13, with x_ext = {x,2'b00}.
- Sits at the receive end of the filtered link.
- Mirrors the encoder arithmetic bit-exactly in modulo-2^13, so recovery is lossless.
- Adds valid handshaking, a warm-up/run/error state machine, a sample counter and a sticky consistency error.

Parameters:
- NB_input, 8, width of the recovered sample x.
- NB_o_fullscale, 13, width of the encoded sample y and all internal history registers (2 fractional bits).
- NB_count, 16, width of the recovered-sample counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  y_in carries a new encoded sample this cycle.
- y_in  input  NB_o_fullscale  encoded sample y[n], unsigned.
- x_out  output  NB_input  recovered sample x[n].
- out_valid  output  1  x_out valid; one-cycle pulse per accepted input.
- err  output  1  sticky: recovered value failed the format check.
- locked  output  1  high in RUN state.
- sample_cnt  output  NB_count  number of samples output since reset; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a clk edge): all history registers (y1, y2, xr1, xr2, xr3) = 0, x_out=0, out_valid=0, err=0, locked=0, sample_cnt=0, state=WARMUP, warm-up count=0.
- Rst has priority over in_valid in the same cycle.
- Decoder reset must coincide with encoder reset so both start from zero history.
- Core equation, all mod 2^13, no saturation: x_rec = y_in - (y1>>1) + (y2>>2) + xr1 - xr2 - xr3.
  - y1, y2 are the last two accepted y_in values.
  - xr1..xr3 are the last three full 13-bit x_rec values, not the 8-bit x_out.
  - Shifts are logical, truncating, identical to the encoder.
- On a cycle with in_valid=1, at the clk edge:
  - x_out <= x_rec[9:2], out_valid <= 1.
  - Shift histories: y2<=y1, y1<=y_in, xr3<=xr2, xr2<=xr1, xr1<=x_rec.
  - Latency: exactly 1 cycle from in_valid to out_valid.
- On a cycle with in_valid=0: histories, x_out and sample_cnt hold; out_valid <= 0. Stalls of any length are allowed.
- Format check on each accepted sample: valid iff x_rec[1:0]==0 and x_rec[12:10]==0. Failure sets err=1.
- err clears only on rst. Output still updates with x_rec[9:2] after an error.
- sample_cnt increments on each accepted sample and stops at 2^NB_count-1.
- FSM:
  - WARMUP: on accepted sample, increment warm count. After the 3rd accepted sample, go to RUN (history fully populated), locked=1 from the following cycle.
  - RUN: stays in RUN while checks pass.
  - ERROR: entered from WARMUP or RUN on any format failure; locked=0. Leaves ERROR only on rst.
  - A failing 3rd sample goes to ERROR, not RUN.
- Arithmetic wraps silently. Intermediate sums use 13-bit modulo, so the order of operations is irrelevant.

Test Plan:
- Reset then y_in=0 for 10 valid cycles -> x_out=0 each cycle, out_valid 1 cycle after each in_valid, locked=1 after 3rd sample, sample_cnt=10, err=0.
- Impulse: y_in sequence 4, 8190 from reset -> x_out=1 then 0; histories hold xr1=0 afterwards.
- Loopback with the encoder on a shared clk/rst, 1000 random x samples including 0 and 255 -> x_out equals x delayed by 1 cycle, err=0 throughout, sample_cnt=1000.
- Loopback with in_valid toggled pseudo-randomly on the decoder side, encoder clock-enabled identically -> exact recovery; out_valid count equals in_valid count; outputs held during stalls.
- From reset, y_in=1 -> x_rec=1, err=1, state ERROR, locked stays 0. Follow with valid encoder data -> err stays 1 until rst; after rst, recovery is correct again.
- Assert rst mid-stream with in_valid=1 on the same cycle -> next cycle all outputs 0, state WARMUP; the first post-reset y_in=20 gives x_out=5.
